// File: rtl/disp7seg_scan.sv
// disp7seg_scan: time-multiplexed hex 7-segment driver with frame-boundary commit; optional DISP7SEG_LZB_EN enables leading-zero blanking
module disp7seg_scan #(
  parameter int NDIGITS    = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clocken,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   data_in,
  input  logic [NDIGITS-1:0]     dp_in,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp_out,
  output logic                   pending,
  output logic                   frame
);
  localparam int IW = $clog2(NDIGITS);
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d, pend_q, pend_d;
  logic [NDIGITS-1:0]     disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                   pending_q, pending_d, frame_q, frame_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NDIGITS-1:0]     lit_v;
  logic [3:0]             nib;
  logic                   show, commit;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

`ifdef DISP7SEG_LZB_EN
  logic lz_acc;
  // digit i stays lit once any nibble or dp at or above it is nonzero; digit 0 always lit
  always_comb begin
    lz_acc = 1'b0;
    lit_v = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      lz_acc = lz_acc | (|disp_q[4*i +: 4]) | disp_dp_q[i];
      lit_v[i] = lz_acc | (i == 0);
    end
  end
`else
  assign lit_v = '1;
`endif

  assign nib    = disp_q[{idx_q, 2'b00} +: 4];
  assign show   = lit_v[idx_q];
  assign commit = clocken & (idx_q == LAST) & pending_q;

  // next state: scan advance, outputs for the strobed digit, pending buffer and commit
  always_comb begin
    idx_d     = clocken ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
    an_d      = clocken ? ((show ? (NDIGITS'(1) << idx_q) : '0) ^ {NDIGITS{ACTIVE_LOW}}) : an_q;
    seg_d     = clocken ? ((show ? hex7(nib) : 7'd0) ^ {7{ACTIVE_LOW}}) : seg_q;
    dp_d      = clocken ? ((show & disp_dp_q[idx_q]) ^ ACTIVE_LOW) : dp_q;
    disp_d    = commit ? pend_q : disp_q;
    disp_dp_d = commit ? pend_dp_q : disp_dp_q;
    pend_d    = load ? data_in : pend_q;
    pend_dp_d = load ? dp_in : pend_dp_q;
    pending_d = load | (pending_q & ~commit);
    frame_d   = commit;
  end

  // state and registered outputs with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q     <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= {NDIGITS{ACTIVE_LOW}};
      seg_q     <= {7{ACTIVE_LOW}};
      dp_q      <= ACTIVE_LOW;
    end else begin
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp_out  = dp_q;
  assign pending = pending_q;
  assign frame   = frame_q;
endmodule

// File: tb/tb_disp7seg_scan.sv
// tb_disp7seg_scan: directed self-checking bench for disp7seg_scan (NDIGITS=4, ACTIVE_LOW=1)
module tb_disp7seg_scan;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clocken = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out, pending, frame;
  int          tests = 0;
  int          fails = 0;
  bit          lzb;

  disp7seg_scan #(.NDIGITS(4), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .clocken(clocken), .load(load),
    .data_in(data_in), .dp_in(dp_in), .an(an), .seg(seg),
    .dp_out(dp_out), .pending(pending), .frame(frame)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe();
    clocken = 1'b1;
    tick();
    clocken = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    return ~oh;
  endfunction

  initial begin
`ifdef DISP7SEG_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'(SOFF));
    chk("rst_dp", 32'(dp_out), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    for (int d = 0; d < 4; d++) begin
      strobe();
      chk($sformatf("t1_an%0d", d), 32'(an), 32'(an_of(d)));
      chk($sformatf("t1_seg%0d", d), 32'(seg), 32'(S0));
      chk($sformatf("t1_dp%0d", d), 32'(dp_out), 32'h1);
      chk($sformatf("t1_frame%0d", d), 32'(frame), 32'h0);
    end
    strobe();
    load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0000;
    tick();
    load = 1'b0;
    chk("t2_pending", 32'(pending), 32'h1);
    strobe();
    chk("t2_old1", 32'(seg), 32'(S0));
    strobe();
    chk("t2_old2", 32'(seg), 32'(S0));
    strobe();
    chk("t2_commit_an", 32'(an), 32'h7);
    chk("t2_commit_seg", 32'(seg), 32'(S0));
    chk("t2_frame", 32'(frame), 32'h1);
    chk("t2_pending0", 32'(pending), 32'h0);
    tick();
    chk("t2_frame_drop", 32'(frame), 32'h0);
    strobe();
    chk("t2_d0", 32'(seg), 32'(SF));
    strobe();
    chk("t2_d1", 32'(seg), 32'(SA));
    strobe();
    chk("t2_d2", 32'(seg), 32'(S2));
    strobe();
    chk("t2_d3", 32'(seg), 32'(S1));
    chk("t2_noframe", 32'(frame), 32'h0);
    load = 1'b1; data_in = 16'h1111;
    tick();
    load = 1'b0;
    strobe();
    chk("t3_old_d0", 32'(seg), 32'(SF));
    strobe();
    strobe();
    clocken = 1'b1; load = 1'b1; data_in = 16'h2222;
    tick();
    clocken = 1'b0; load = 1'b0;
    chk("t3_commit_seg", 32'(seg), 32'(S1));
    chk("t3_frame", 32'(frame), 32'h1);
    chk("t3_pending_kept", 32'(pending), 32'h1);
    strobe();
    chk("t3_d0_1111", 32'(seg), 32'(S1));
    strobe();
    strobe();
    strobe();
    chk("t3_d3_1111", 32'(seg), 32'(S1));
    chk("t3_frame2", 32'(frame), 32'h1);
    chk("t3_pending0", 32'(pending), 32'h0);
    strobe();
    chk("t3_d0_2222", 32'(seg), 32'(S2));
    strobe();
    load = 1'b1; data_in = 16'h3333;
    tick();
    load = 1'b0;
    chk("t4_pending_pre", 32'(pending), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_an", 32'(an), 32'hF);
    chk("t4_seg", 32'(seg), 32'(SOFF));
    chk("t4_pending", 32'(pending), 32'h0);
    strobe();
    chk("t4_restart_an", 32'(an), 32'hE);
    chk("t4_restart_seg", 32'(seg), 32'(S0));
    load = 1'b1; data_in = 16'h0040; dp_in = 4'b0000;
    tick();
    load = 1'b0;
    strobe();
    strobe();
    strobe();
    chk("t5_frame", 32'(frame), 32'h1);
    strobe();
    chk("t5_d0_an", 32'(an), 32'hE);
    chk("t5_d0_seg", 32'(seg), 32'(S0));
    strobe();
    chk("t5_d1_an", 32'(an), 32'hD);
    chk("t5_d1_seg", 32'(seg), 32'(S4));
    for (int d = 2; d < 4; d++) begin
      strobe();
      chk($sformatf("t5_d%0d_an", d), 32'(an), lzb ? 32'hF : 32'(an_of(d)));
      chk($sformatf("t5_d%0d_seg", d), 32'(seg), lzb ? 32'(SOFF) : 32'(S0));
      chk($sformatf("t5_d%0d_dp", d), 32'(dp_out), 32'h1);
    end
    load = 1'b1; data_in = 16'h0000; dp_in = 4'b0010;
    tick();
    load = 1'b0;
    clocken = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t6_an%0d", c), 32'(an), (lzb && (c % 4) >= 2) ? 32'hF : 32'(an_of(c % 4)));
      chk($sformatf("t6_frame%0d", c), 32'(frame), (c == 3) ? 32'h1 : 32'h0);
      chk($sformatf("t6_dp%0d", c), 32'(dp_out), (c == 5 || c == 9) ? 32'h0 : 32'h1);
    end
    clocken = 1'b0;
    tick();
    chk("t6_hold_an", 32'(an), 32'hD);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
